mmcm_rst_seq: RTL

Parametrised reset sequencer for an MMCM-based clock generator driving N downstream clock domains. Runs in the reference-clock domain. Generates the MMCM reset pulse, synchronises MMCM lock, pulses the BUFR reset on lock, and releases per-domain resets in index order. Adds lock timeout with bounded retry, a sticky failure state and a software-forced re-lock. Sits between the board reset and the MMCM/BUFR/SERDES logic of the DVI TX clocking path.

---
 rtl/mmcm_rst_seq_pkg.sv | 24 ++
 rtl/mmcm_rst_seq_if.sv | 46 ++++
 rtl/mmcm_rst_seq_sync.sv | 32 +++
 rtl/mmcm_rst_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mmcm_rst_seq_pkg.sv
// Shared types and width helpers for the MMCM reset sequencer.
package mmcm_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_RST_PULSE = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    // $clog2 that never returns less than one bit.
    function automatic int clog2_min1(input int value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mmcm_rst_seq_if.sv
// Lock/force inputs and reset/status outputs of the MMCM reset sequencer.
interface mmcm_rst_seq_if
    import mmcm_rst_seq_pkg::*;
#(
    parameter int N_DOMAINS = 3,
    parameter int MAX_RETRY = 3
);
    localparam int RETRY_W = clog2_min1(MAX_RETRY + 1);

    logic                 i_mmcm_locked;
    logic                 i_force_rst;
    logic                 o_mmcm_rst;
    logic                 o_bufr_rst;
    logic [N_DOMAINS-1:0] o_dom_rst;
    logic                 o_slocked;
    logic                 o_ready;
    logic                 o_fail;
    logic [RETRY_W-1:0]   o_retry_cnt;

    // Sequencer side.
    modport master (
        input  i_mmcm_locked,
        input  i_force_rst,
        output o_mmcm_rst,
        output o_bufr_rst,
        output o_dom_rst,
        output o_slocked,
        output o_ready,
        output o_fail,
        output o_retry_cnt
    );

    // Clocking-path / software side.
    modport slave (
        output i_mmcm_locked,
        output i_force_rst,
        input  o_mmcm_rst,
        input  o_bufr_rst,
        input  o_dom_rst,
        input  o_slocked,
        input  o_ready,
        input  o_fail,
        input  o_retry_cnt
    );

endinterface

// File: rtl/mmcm_rst_seq_sync.sv
// Flop chain used both as the lock synchroniser and as the reset
// deassertion bridge (async clear, synchronous release of the constant input).
module mmcm_rst_seq_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Shift the input one stage per clock.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], i_d};
    end

    // Chain registers, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign o_q = chain_q[STAGES-1];

endmodule

// File: rtl/mmcm_rst_seq.sv
// MMCM reset sequencer: pulses the MMCM reset, waits for a synchronised lock
// with timeout and bounded retry, pulses the BUFR clear, then releases the
// downstream domain resets one at a time in index order.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_RST_PULSE | MMCM reset held high for RST_PULSE_CYC cycles
// ST_WAIT_LOCK | MMCM running, waiting up to LOCK_TIMEOUT_CYC for lock
// ST_SETTLE    | BUFR clear pulsed on entry, wait SETTLE_CYC
// ST_RELEASE   | domain idx released, wait SETTLE_CYC before the next one
// ST_RUN       | all domains released, lock held
// ST_FAIL      | retries exhausted, MMCM held in reset until forced
module mmcm_rst_seq
    import mmcm_rst_seq_pkg::*;
#(
    parameter int N_DOMAINS        = 3,
    parameter int RST_PULSE_CYC    = 8,
    parameter int LOCK_TIMEOUT_CYC = 125000,
    parameter int SETTLE_CYC       = 16,
    parameter int SYNC_STAGES      = 2,
    parameter int MAX_RETRY        = 3
) (
    input  logic           i_clk,
    input  logic           i_arst_n,
    mmcm_rst_seq_if.master bus
);

    localparam int CNT_W   = clog2_min1(max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, SETTLE_CYC) + 1);
    localparam int IDX_W   = clog2_min1(N_DOMAINS);
    localparam int RETRY_W = clog2_min1(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(N_DOMAINS - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

    logic rst_sync_n;
    logic slocked;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 mmcm_rst_q, mmcm_rst_d;
    logic                 bufr_rst_q, bufr_rst_d;
    logic [N_DOMAINS-1:0] dom_rst_q, dom_rst_d;
    logic                 ready_q, ready_d;
    logic                 fail_q, fail_d;

    // Reset bridge: asserts with i_arst_n, releases two clocks later.
    mmcm_rst_seq_sync #(
        .STAGES  (2),
        .RST_VAL (1'b0)
    ) u_rst_bridge (
        .i_clk   (i_clk),
        .i_rst_n (i_arst_n),
        .i_d     (1'b1),
        .o_q     (rst_sync_n)
    );

    // Lock synchroniser; its last flop is the registered o_slocked.
    mmcm_rst_seq_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_arst_n),
        .i_d     (bus.i_mmcm_locked),
        .o_q     (slocked)
    );

    // Next-state, shared counter, release index, retry count and registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        idx_d     = idx_q;
        retry_d   = retry_q;
        dom_rst_d = dom_rst_q;

        // Force beats any timeout or lock event in the same cycle.
        if (bus.i_force_rst && (state_q != ST_RST_PULSE)) begin
            state_d = ST_RST_PULSE;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RST_PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (slocked) begin
                        state_d = ST_SETTLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 1'b1;
                            state_d = ST_RST_PULSE;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (!slocked) begin
                        state_d = ST_RST_PULSE;
                        retry_d = '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d      = ST_RELEASE;
                        idx_d        = '0;
                        dom_rst_d[0] = 1'b0;
                    end
                end
                ST_RELEASE: begin
                    if (!slocked) begin
                        state_d = ST_RST_PULSE;
                        retry_d = '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                        end else begin
                            idx_d            = idx_q + 1'b1;
                            dom_rst_d[idx_d] = 1'b0;
                            cnt_d            = '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (!slocked) begin
                        state_d = ST_RST_PULSE;
                        retry_d = '0;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RST_PULSE;
                end
            endcase
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Every state outside RELEASE/RUN holds all domains in reset.
        if ((state_d != ST_RELEASE) && (state_d != ST_RUN)) begin
            dom_rst_d = '1;
        end

        mmcm_rst_d = (state_d == ST_RST_PULSE) || (state_d == ST_FAIL);
        bufr_rst_d = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);
        ready_d    = (state_d == ST_RUN);
        fail_d     = (state_d == ST_FAIL);
    end

    // FSM and output registers, held in reset until the bridge releases.
    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q    <= ST_RST_PULSE;
            cnt_q      <= '0;
            idx_q      <= '0;
            retry_q    <= '0;
            mmcm_rst_q <= 1'b1;
            bufr_rst_q <= 1'b0;
            dom_rst_q  <= '1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            mmcm_rst_q <= mmcm_rst_d;
            bufr_rst_q <= bufr_rst_d;
            dom_rst_q  <= dom_rst_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end

    assign bus.o_mmcm_rst  = mmcm_rst_q;
    assign bus.o_bufr_rst  = bufr_rst_q;
    assign bus.o_dom_rst   = dom_rst_q;
    assign bus.o_slocked   = slocked;
    assign bus.o_ready     = ready_q;
    assign bus.o_fail      = fail_q;
    assign bus.o_retry_cnt = retry_q;

endmodule
